// File: rtl/case_9_dot_acc_pkg.sv
// Shared types and default sizing for the case_9 streaming dot-product accumulator.
package case_9_dot_acc_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int DEF_DIN_WIDTH = 7;
  localparam int DEF_LEN       = 8;
  localparam int DEF_ACC_WIDTH = 10;
  localparam int DEF_OUT_WIDTH = 8;

  // Width of a counter that spans 0..len-1; never narrower than one bit.
  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/case_9_sat_clamp.sv
// Combinational signed clamp from ACC_WIDTH down to OUT_WIDTH, with a clamp flag.
module case_9_sat_clamp
  import case_9_dot_acc_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  // Bounds built bit-exactly so no integer arithmetic limits the widths.
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

  always_comb begin
    dout = din[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (din > MAX_V) begin
      dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (din < MIN_V) begin
      dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/case_9_dot_acc.sv
// Streaming signed accumulator: sums LEN products per frame and holds the result on a valid/ready port.
// Output clamping is compiled in when CASE_9_DOT_ACC_SAT_EN is defined; otherwise the sum wraps.
module case_9_dot_acc
  import case_9_dot_acc_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int LEN       = DEF_LEN,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_sat
);

  localparam int CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t                        state_r;
  state_t                        state_nxt;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic        [CNT_W-1:0]       cnt;
  logic signed [ACC_WIDTH-1:0]   din_ext;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [OUT_WIDTH-1:0]   conv;
  logic signed [OUT_WIDTH-1:0]   dout_r;
  logic                          accept;
  logic                          last;

  assign din_ext    = ACC_WIDTH'(din);
  assign sum        = acc + din_ext;
  assign accept     = (state_r == ST_ACC) && din_valid;
  assign last       = (cnt == LAST);
  assign din_ready  = (state_r == ST_ACC);
  assign dout_valid = (state_r == ST_HOLD);
  assign dout       = dout_r;

`ifdef CASE_9_DOT_ACC_SAT_EN
  logic conv_sat;
  logic sat_r;

  case_9_sat_clamp #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_clamp (
    .din  (sum),
    .dout (conv),
    .sat  (conv_sat)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_r <= 1'b0;
    end else if (accept && last) begin
      sat_r <= conv_sat;
    end
  end

  assign dout_sat = sat_r;
`else
  assign conv     = sum[OUT_WIDTH-1:0];
  assign dout_sat = 1'b0;
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= ST_ACC;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_ACC:  if (accept && last) state_nxt = ST_HOLD;
      ST_HOLD: if (dout_ready)     state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  // Accumulate stage: the final product goes straight into the result register from the full sum.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc    <= '0;
      cnt    <= '0;
      dout_r <= '0;
    end else if (accept) begin
      if (last) begin
        dout_r <= conv;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_case_9_dot_acc.sv
// Self-checking bench for case_9_dot_acc: directed corner frames plus randomized gapped frames
// compared against a plain-arithmetic frame-sum model. Follows CASE_9_DOT_ACC_SAT_EN if defined.
module tb_case_9_dot_acc;

  localparam int DIN_WIDTH = 7;
  localparam int LEN       = 8;
  localparam int ACC_WIDTH = 10;
  localparam int OUT_WIDTH = 8;

  logic                        ap_clk = 1'b0;
  logic                        ap_rst = 1'b1;
  logic signed [DIN_WIDTH-1:0] din = '0;
  logic                        din_valid = 1'b0;
  logic                        din_ready;
  logic signed [OUT_WIDTH-1:0] dout;
  logic                        dout_valid;
  logic                        dout_ready = 1'b0;
  logic                        dout_sat;

  int n_cmp = 0;
  int n_err = 0;

  case_9_dot_acc #(
    .DIN_WIDTH (DIN_WIDTH),
    .LEN       (LEN),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sat   (dout_sat)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference conversion of a frame sum to the output port.
  function automatic int ref_out(input int s, output int sat);
    int hi;
    int lo;
    int w;
    hi  = (1 << (OUT_WIDTH - 1)) - 1;
    lo  = -(1 << (OUT_WIDTH - 1));
    sat = 0;
`ifdef CASE_9_DOT_ACC_SAT_EN
    if (s > hi) begin
      sat = 1;
      return hi;
    end
    if (s < lo) begin
      sat = 1;
      return lo;
    end
    return s;
`else
    w = s & ((1 << OUT_WIDTH) - 1);
    if (w > hi) w = w - (1 << OUT_WIDTH);
    return w;
`endif
  endfunction

  // Offer one product at a negedge; it is taken on the following posedge.
  task automatic send(input int v, input bit gaps);
    if (gaps) begin
      int n;
      n = $urandom_range(2, 0);
      for (int g = 0; g < n; g++) begin
        din_valid  = 1'b0;
        din        = DIN_WIDTH'($urandom);
        dout_ready = 1'(($urandom));
        @(negedge ap_clk);
      end
    end
    check_eq("din_ready_acc", int'(din_ready), 1);
    din        = DIN_WIDTH'(v);
    din_valid  = 1'b1;
    dout_ready = 1'(($urandom));
    @(negedge ap_clk);
    din_valid = 1'b0;
  endtask

  // Feed one full frame, check the held result, then release it (or reset while holding).
  task automatic run_frame(input string name, input int vals[LEN], input bit gaps,
                           input int hold, input bit rst_in_hold);
    int s;
    int exp_d;
    int exp_s;
    s = 0;
    for (int i = 0; i < LEN; i++) begin
      send(vals[i], gaps);
      s += vals[i];
    end
    exp_d = ref_out(s, exp_s);
    dout_ready = 1'b0;
    check_eq({name, "_valid"}, int'(dout_valid), 1);
    check_eq({name, "_dinrdy"}, int'(din_ready), 0);
    check_eq({name, "_dout"}, int'(dout), exp_d);
    check_eq({name, "_sat"}, int'(dout_sat), exp_s);
    for (int k = 0; k < hold; k++) begin
      din_valid = 1'b1;
      din       = DIN_WIDTH'($urandom);
      @(negedge ap_clk);
      check_eq({name, "_hold_valid"}, int'(dout_valid), 1);
      check_eq({name, "_hold_dinrdy"}, int'(din_ready), 0);
      check_eq({name, "_hold_dout"}, int'(dout), exp_d);
      check_eq({name, "_hold_sat"}, int'(dout_sat), exp_s);
    end
    din_valid = 1'b1;
    din       = DIN_WIDTH'($urandom);
    if (rst_in_hold) begin
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      check_eq({name, "_rst_dout"}, int'(dout), 0);
      check_eq({name, "_rst_sat"}, int'(dout_sat), 0);
    end else begin
      dout_ready = 1'b1;
      @(negedge ap_clk);
      dout_ready = 1'b0;
    end
    din_valid = 1'b0;
    check_eq({name, "_exit_valid"}, int'(dout_valid), 0);
    check_eq({name, "_exit_dinrdy"}, int'(din_ready), 1);
  endtask

  initial begin
    int v[LEN];

    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    check_eq("reset_dinrdy", int'(din_ready), 1);
    check_eq("reset_valid", int'(dout_valid), 0);
    check_eq("reset_dout", int'(dout), 0);
    check_eq("reset_sat", int'(dout_sat), 0);

    for (int i = 0; i < LEN; i++) v[i] = i + 1;
    run_frame("ramp", v, 1'b0, 0, 1'b0);

    for (int i = 0; i < LEN; i++) v[i] = 63;
    run_frame("maxpos", v, 1'b0, 0, 1'b0);

    for (int i = 0; i < LEN; i++) v[i] = -64;
    run_frame("minneg", v, 1'b0, 1, 1'b0);

    for (int i = 0; i < LEN; i++) v[i] = 2;
    run_frame("bp", v, 1'b0, 5, 1'b0);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < LEN; i++) v[i] = $urandom_range(127, 0) - 64;
      run_frame($sformatf("rnd%0d", f), v, 1'b1, $urandom_range(3, 0), 1'b0);
    end

    // Partial frame discarded by a reset pulse.
    for (int i = 0; i < 3; i++) send(5, 1'b0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    check_eq("midrst_dinrdy", int'(din_ready), 1);
    check_eq("midrst_valid", int'(dout_valid), 0);

    for (int i = 0; i < LEN; i++) v[i] = 1;
    run_frame("after_rst", v, 1'b0, 2, 1'b1);

    for (int i = 0; i < LEN; i++) v[i] = $urandom_range(127, 0) - 64;
    run_frame("post_hold_rst", v, 1'b1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/case_9_dot_acc.md
# case_9_dot_acc

Streaming signed accumulator that sits directly downstream of the case_9 7s×6s→7 multiplier. It consumes one 7-bit signed product per handshake and sums LEN consecutive products into one frame result. It then presents the result on a valid/ready output port. Optional output saturation clamps the frame sum to the output width.

## Interface
- DIN_WIDTH, 7: width of signed product input.
- LEN, 8: products per frame; must be ≥2.
- ACC_WIDTH, 10: internal accumulator width; must satisfy ACC_WIDTH ≥ DIN_WIDTH + $clog2(LEN), so the accumulator never overflows.
- OUT_WIDTH, 8: signed result width; must satisfy OUT_WIDTH ≤ ACC_WIDTH.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- din  in  DIN_WIDTH  signed product from the multiplier.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle.
- dout  out  OUT_WIDTH  signed frame result.
- dout_valid  out  1  dout holds a complete frame result.
- dout_ready  in  1  downstream accepts dout.
- dout_sat  out  1  result was clamped; constant 0 when saturation is compiled out.

## Operation
- Two states:
  - ACC: accepting products.
  - HOLD: presenting a result.
- Accept event: state == ACC and din_valid && din_ready.
- On each accept:
  - acc ← acc + sign_extend(din).
  - cnt ← cnt + 1.
- Final accept (cnt == LEN-1):
  - the result register is loaded from the full sum acc + din;
  - acc and cnt clear to 0;
  - state → HOLD.
- In HOLD:
  - din_ready = 0 and dout_valid = 1.
  - dout and dout_sat stay stable until dout_ready is sampled high.
  - When dout_ready is sampled high, state → ACC.
- din_valid low in ACC: no state change, acc and cnt hold (gaps allowed).
- din_ready = (state == ACC). It is registered-state-derived and has no combinational path from dout_ready. One bubble cycle per frame is accepted.
- Output conversion of the full sum S:
  - If S lies within the OUT_WIDTH signed range, dout = S[OUT_WIDTH-1:0] and dout_sat = 0.
  - Out of range: behaviour is set by the macro (see Configuration).
- Reset asserted in any cycle, including mid-frame or in HOLD:
  - next edge: state = ACC, acc = 0, cnt = 0, dout = 0, dout_valid = 0, dout_sat = 0;
  - any partial frame or un-accepted result is discarded.

## Timing
- Reset values: din_ready = 1 (state ACC), dout_valid = 0, dout = 0, dout_sat = 0.
- Latency: dout_valid rises on the clock edge that accepts the LEN-th product, i.e. visible the cycle after that accept.
- Throughput: LEN accept cycles plus at least one HOLD cycle per frame.
- HOLD exit: dout_ready high in a HOLD cycle → that cycle's edge clears dout_valid and sets din_ready = 1 for the next cycle.
- A new product is never accepted in the same cycle that a result is consumed.
- All outputs are registers or decode the state register only.

## Configuration
- CASE_9_DOT_ACC_SAT_EN defined:
  - S > 2^(OUT_WIDTH-1)-1 → dout = max positive, dout_sat = 1.
  - S < -2^(OUT_WIDTH-1) → dout = min negative, dout_sat = 1.
- Not defined:
  - dout = S[OUT_WIDTH-1:0] (two's-complement wrap);
  - dout_sat is tied to 0 and no clamp logic is generated.

## Structure
- Package case_9_dot_acc_pkg holds:
  - state enum (ST_ACC, ST_HOLD);
  - default width/LEN localparams;
  - a $clog2-based counter width function.
- One sub-module: case_9_sat_clamp. It is combinational and ACC_WIDTH→OUT_WIDTH. It outputs the clamped value plus a flag, and is instantiated only under CASE_9_DOT_ACC_SAT_EN.
- Counter, accumulator, result register and FSM live in the top module.

## Test plan
- Defaults, 8 products 1..8 back-to-back, dout_ready = 1 → dout = 36, dout_sat = 0; dout_valid high exactly one cycle; din_ready low that cycle.
- 8 × (+63):
  - with SAT_EN → dout = 127, dout_sat = 1;
  - without → dout = 0xF8 (-8), dout_sat = 0.
- 8 × (-64):
  - with SAT_EN → dout = -128, dout_sat = 1;
  - without → dout = 0x00.
- Backpressure: frame of 8 × 2, dout_ready held low 5 cycles → dout = 16 stable, dout_valid = 1, din_ready = 0 throughout. Raise dout_ready → next frame accepted from the following cycle.
- Random din_valid gaps (≈50% duty) over 3 frames → each result equals the scoreboard sum. Check that no product is dropped or duplicated across frame boundaries.
- Reset mid-operation: 3 products of 5 accepted, pulse ap_rst one cycle, then 8 × 1 → dout = 8. A second ap_rst pulse while in HOLD → dout_valid = 0 next cycle.
